// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer for the higher/lower key game.
// An LFSR supplies the hex digits. The block judges each higher/lower key press
// and keeps lives and score. It drives the four display nibbles in3..in0.
//
// Optional build macro GUESS_TIMEOUT_EN enables the per-guess timeout timer.
// Without it there is no timer, WAIT_GUESS waits indefinitely for a key, and
// TIMEOUT_CYCLES has no effect.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | after reset, waiting for start
// WAIT_GUESS | digit shown, waiting for a key press (or timeout)
// EVAL       | one cycle: draw the next digit and judge the guess
// OVER       | lives exhausted, outputs frozen until start

module guess_round_ctrl #(
   parameter int          TIMEOUT_CYCLES = 100_000_000,
   parameter int          LIVES          = 3,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       res,
   input  logic       start,
   input  logic       key_valid,
   input  logic       check,
   output logic [3:0] in0,
   output logic [3:0] in1,
   output logic [3:0] in2,
   output logic [3:0] in3,
   output logic       round_active,
   output logic       game_over
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_GUESS = 2'd1,
      EVAL       = 2'd2,
      OVER       = 2'd3
   } state_t;

   // Reject parameter sets that the lives nibble or the LFSR cannot support.
   if (TIMEOUT_CYCLES < 2 || LIVES < 1 || LIVES > 15 || LFSR_SEED == 16'h0000) begin : g_param_check
      $error("guess_round_ctrl: illegal parameter value");
   end

   state_t      state;
   logic [15:0] lfsr;
   logic [3:0]  cur;
   logic [3:0]  lives;
   logic [7:0]  score;
   logic        dir;
   logic        wrong_forced;
   logic        timeout;
   logic        correct;
   logic [3:0]  rnd;

   assign rnd = lfsr[3:0];

`ifdef GUESS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer;

   assign timeout = (timer == TW'(TIMEOUT_CYCLES - 1));

   // Per-guess timer: counts while waiting, cleared at game start and after each evaluation.
   always_ff @(posedge clk) begin
      if (res) begin
         timer <= '0;
      end else begin
         case (state)
            WAIT_GUESS: timer <= timer + TW'(1);
            EVAL:       timer <= '0;
            default:    if (start) timer <= '0;
         endcase
      end
   end
`else
   assign timeout      = 1'b0;
   assign wrong_forced = 1'b0;
`endif

   // A tie counts as correct for either direction; a forced wrong is never correct.
   assign correct = !wrong_forced && (dir ? (rnd >= cur) : (rnd <= cur));

   // Galois right-shift LFSR; free-running in every state except reset.
   always_ff @(posedge clk) begin
      if (res) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   // Game FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (res) begin
         state        <= IDLE;
         cur          <= 4'h0;
         lives        <= 4'(LIVES);
         score        <= 8'h00;
         dir          <= 1'b0;
`ifdef GUESS_TIMEOUT_EN
         wrong_forced <= 1'b0;
`endif
         round_active <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  cur          <= rnd;
                  lives        <= 4'(LIVES);
                  score        <= 8'h00;
                  state        <= WAIT_GUESS;
                  round_active <= 1'b1;
                  game_over    <= 1'b0;
               end
            end
            WAIT_GUESS: begin
               // A key press in the timeout cycle still counts as a real guess.
               if (key_valid) begin
                  dir          <= check;
`ifdef GUESS_TIMEOUT_EN
                  wrong_forced <= 1'b0;
`endif
                  state        <= EVAL;
               end else if (timeout) begin
`ifdef GUESS_TIMEOUT_EN
                  wrong_forced <= 1'b1;
`endif
                  state        <= EVAL;
               end
            end
            EVAL: begin
               cur <= rnd;
               if (correct) begin
                  if (score != 8'hFF) score <= score + 8'd1;
               end else begin
                  lives <= lives - 4'd1;
               end
               if (!correct && lives == 4'd1) begin
                  state        <= OVER;
                  round_active <= 1'b0;
                  game_over    <= 1'b1;
               end else begin
                  state        <= WAIT_GUESS;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in0 = cur;
   assign in1 = lives;
   assign in2 = score[3:0];
   assign in3 = score[7:4];

endmodule
